code_conv_pipe: RTL
===================

// Module: code_conv_pipe
// PURPOSE
//  Parametrised, pipelined 4-mode code converter: successor to the fixed 4-bit combinational converter schematic.
//  Accepts W-bit words with a per-word mode on a valid/ready stream, returns converted words 2 cycles later.
//  Sits between the switch/stimulus front end and the display/result logic; fully stallable by downstream.
// PARAMETERS
//  W      4   data width in bits (>=2)
//  CNT_W  8   width of the completed-transfer counter
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input word present
//  in_ready   out  1      block can accept input this cycle
//  in_data    in   W      input word (bit W-1 = MSB, as x3..x0)
//  in_mode    in   2      conversion mode for this word
//  out_valid  out  1      result word present
//  out_ready  in   1      downstream accepts result this cycle
//  out_data   out  W      converted word (as y3..y0)
//  out_mode   out  2      mode that produced out_data
//  xfer_cnt   out  CNT_W  count of completed output handshakes
//  out_parity out  1      XOR of out_data (only with CODE_CONV_PARITY_EN)
// BEHAVIOUR
//  Modes: 00 PASS y=x; 01 BIN2GRAY y=x^(x>>1); 10 GRAY2BIN y[i]=^x[W-1:i];
//         11 NEG y=(~x+1) mod 2^W (0 -> 0, 100..0 -> 100..0).
//  Pipeline: S1 registers in_data/in_mode; S2 registers converted result/mode. Latency 2 cycles from accept.
//  adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational, no bubble).
//  Accept when in_valid & in_ready. Output transfer when out_valid & out_ready.
//  Full throughput: one word per cycle while out_ready=1.
//  Stall: out_valid & !out_ready holds out_data/out_mode stable; S1 holds if full; in_ready=0 when both full.
//  in_data/in_mode sampled only on accept; ignored otherwise. Mode never changes a word in flight.
//  Simultaneous accept and output transfer on a full pipe: both occur, no word lost or duplicated.
//  xfer_cnt += 1 on each output transfer, wraps 2^CNT_W-1 -> 0.
//  Reset (any time, incl. mid-stall): s1_valid=s2_valid=0, out_valid=0, out_data=0, out_mode=0, xfer_cnt=0, out_parity=0.
//    In-flight words discarded; in_ready=1 on first cycle after rst deasserts.
// CONFIGURATION
//  CODE_CONV_PARITY_EN defined: out_parity port present, registered with S2, equals ^out_data; stalls with it.
//  Not defined: out_parity port and its register absent; all other behaviour identical.
// STRUCTURE
//  code_conv_pkg: localparams MODE_PASS=2'b00, MODE_B2G=2'b01, MODE_G2B=2'b10, MODE_NEG=2'b11; mode width 2.
//  Sub-module code_conv_core (combinational, param W): in x, mode -> y; instantiated between S1 and S2.
//  Top holds S1/S2 registers, ready/valid logic, xfer_cnt, optional parity register.
// TESTING (W=4 unless noted)
//  1 Exhaustive: all 16 x in each mode, out_ready=1 -> e.g. B2G 0111->0100, G2B 0100->0111, NEG 0001->1111, NEG 1000->1000; 2-cycle latency.
//  2 Back-to-back 16 words, out_ready=1 -> 16 results on consecutive cycles, in_ready stays 1, xfer_cnt=16.
//  3 Hold out_ready=0 for 5 cycles after 3 accepts -> in_ready=0 after 2 accepts, out_data stable; release -> 3rd word delivered, order kept.
//  4 Full pipe, in_valid=1 & out_ready=1 same cycle -> one in, one out, no loss/duplication.
//  5 Assert rst mid-stall with 2 words in flight -> out_valid=0, xfer_cnt=0 at once; next word after release returns correctly.
//  6 CNT_W=2, 5 transfers -> xfer_cnt 1,2,3,0,1; with CODE_CONV_PARITY_EN, B2G 0111 -> out_parity=1.

Source files
------------

// File: rtl/code_conv_pkg.sv
// Shared constants for the pipelined code converter: mode encodings and mode width.
package code_conv_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_PASS = 2'b00;
  localparam mode_t MODE_B2G  = 2'b01;
  localparam mode_t MODE_G2B  = 2'b10;
  localparam mode_t MODE_NEG  = 2'b11;

endpackage

// File: rtl/code_conv_core.sv
// Combinational W-bit converter: pass, binary->Gray, Gray->binary, two's-complement negate.
module code_conv_core
  import code_conv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]      x,
  input  logic [MODE_W-1:0] mode,
  output logic [W-1:0]      y
);

  logic [W-1:0] gray_s;
  logic [W-1:0] bin_s;
  logic [W-1:0] neg_s;

  assign gray_s = x ^ (x >> 1);
  assign neg_s  = ~x + {{(W-1){1'b0}}, 1'b1};

  // Gray->binary as a prefix XOR running from the MSB down
  always_comb begin
    bin_s        = {W{1'b0}};
    bin_s[W-1]   = x[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin_s[i] = bin_s[i+1] ^ x[i];
    end
  end

  // Mode select
  always_comb begin
    y = x;
    case (mode)
      MODE_PASS: y = x;
      MODE_B2G:  y = gray_s;
      MODE_G2B:  y = bin_s;
      MODE_NEG:  y = neg_s;
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/code_conv_pipe.sv
// Two-stage stallable valid/ready code converter with completed-transfer counter.
// Optional out_parity output enabled by defining CODE_CONV_PARITY_EN.
module code_conv_pipe
  import code_conv_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [MODE_W-1:0] out_mode,
  output logic [CNT_W-1:0]  xfer_cnt
`ifdef CODE_CONV_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  function automatic logic calc_parity(input logic [W-1:0] d);
    return ^d;
  endfunction

  logic              s1_valid_r;
  logic [W-1:0]      s1_data_r;
  logic [MODE_W-1:0] s1_mode_r;
  logic              s2_valid_r;
  logic [W-1:0]      s2_data_r;
  logic [MODE_W-1:0] s2_mode_r;
  logic [CNT_W-1:0]  xfer_cnt_r;
  logic [W-1:0]      conv_s;
  logic              adv1_s;
  logic              adv2_s;
  logic              accept_s;
  logic              xfer_s;

  // Each stage may advance when it is empty or the stage after it is moving
  assign adv2_s   = !s2_valid_r || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign accept_s = in_valid && adv1_s;
  assign xfer_s   = s2_valid_r && out_ready;

  code_conv_core #(.W(W)) u_core (
    .x    (s1_data_r),
    .mode (s1_mode_r),
    .y    (conv_s)
  );

  // Stage 1: capture the raw word and its mode on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {W{1'b0}};
      s1_mode_r  <= MODE_PASS;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (accept_s) begin
        s1_data_r <= in_data;
        s1_mode_r <= in_mode;
      end
    end
  end

  // Stage 2: capture the converted word; held stable while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {W{1'b0}};
      s2_mode_r  <= MODE_PASS;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= conv_s;
        s2_mode_r <= s1_mode_r;
      end
    end
  end

  // Completed output handshakes, wrapping at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else if (xfer_s) begin
      xfer_cnt_r <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef CODE_CONV_PARITY_EN
  logic parity_r;

  // Parity travels with stage 2 so it always matches out_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (adv2_s && s1_valid_r) begin
      parity_r <= calc_parity(conv_s);
    end
  end

  assign out_parity = parity_r;
`endif

  assign in_ready  = adv1_s;
  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_mode  = s2_mode_r;
  assign xfer_cnt  = xfer_cnt_r;

endmodule
